// File: rtl/branch_fu_q.sv
// branch_fu_q: conditional-branch unit with DEPTH-entry result FIFO and dual CDB/ROB delivery.
// BRANCHFU_RELATIVE_EN enables PC-relative targets selected by operand[0].
module branch_fu_q #(
   parameter int DATA_W    = 8,
   parameter int ROBID_W   = 4,
   parameter int DEPTH     = 4,
   parameter int TAKEN_BIT = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   input_transmit,
   input  logic [7:0]             operand,
   input  logic [1:0][DATA_W-1:0] depvals,
   input  logic [DATA_W-1:0]      pc,
   input  logic [7:0]             wbs,
   input  logic [7:0]             flags,
   input  logic [ROBID_W-1:0]     robid,
   input  logic                   cdb_transmit,
   output logic                   cdb_transmit_out,
   output logic [ROBID_W-1:0]     cdb_id,
   output logic [DATA_W-1:0]      cdb_val,
   input  logic                   rob_transmit,
   output logic                   rob_transmit_out,
   output logic [ROBID_W-1:0]     robid_out,
   output logic [7:0]             flags_out,
   output logic [7:0]             wbs_out,
   output logic [DATA_W-1:0]      value_out,
   output logic                   busy
);
   localparam int PW = $clog2(DEPTH);

   logic [ROBID_W-1:0] id_q  [DEPTH];
   logic [7:0]         wbs_q [DEPTH];
   logic [7:0]         flg_q [DEPTH];
   logic [DATA_W-1:0]  tgt_q [DEPTH];
   logic [PW-1:0]      wr_ptr, rd_ptr;
   logic [PW:0]        count;
   logic               cdb_done, rob_done;
   logic [DATA_W-1:0]  a, b, target;
   logic [1:0]         idx;
   logic               taken, head_v, cdb_fire, rob_fire, accept, retire;
   logic [7:0]         new_flags;
   logic               unused_ok;

   assign a = depvals[0];
   assign b = depvals[1];
   assign idx = {a[DATA_W-1], |a[DATA_W-2:0]};
   assign taken = operand[4 + idx];

`ifdef BRANCHFU_RELATIVE_EN
   assign target = operand[0] ? pc + b : b;
   assign unused_ok = ^operand[3:1];
`else
   assign target = b;
   assign unused_ok = ^{pc, operand[3:0]};
`endif

   always_comb begin
      new_flags = flags;
      new_flags[TAKEN_BIT] = taken;
   end

   assign busy = count == (PW+1)'(DEPTH);
   assign head_v = count != '0;
   assign cdb_transmit_out = head_v & ~cdb_done;
   assign rob_transmit_out = head_v & ~rob_done;
   assign cdb_fire = cdb_transmit_out & cdb_transmit;
   assign rob_fire = rob_transmit_out & rob_transmit;
   // Head leaves once each channel is either already done or taking it now.
   assign retire = head_v & (cdb_done | cdb_fire) & (rob_done | rob_fire);
   assign accept = input_transmit & ~busy;

   assign cdb_id    = id_q[rd_ptr];
   assign robid_out = id_q[rd_ptr];
   assign cdb_val   = tgt_q[rd_ptr];
   assign value_out = tgt_q[rd_ptr];
   assign flags_out = flg_q[rd_ptr];
   assign wbs_out   = wbs_q[rd_ptr];

   // Storage is reset too so every output reads zero straight out of reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            id_q[i]  <= '0;
            wbs_q[i] <= '0;
            flg_q[i] <= '0;
            tgt_q[i] <= '0;
         end
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         cdb_done <= 1'b0;
         rob_done <= 1'b0;
      end else begin
         if (accept) begin
            id_q[wr_ptr]  <= robid;
            wbs_q[wr_ptr] <= wbs;
            flg_q[wr_ptr] <= new_flags;
            tgt_q[wr_ptr] <= target;
            wr_ptr        <= wr_ptr + PW'(1);
         end
         if (retire) rd_ptr <= rd_ptr + PW'(1);
         count    <= count + {{PW{1'b0}}, accept} - {{PW{1'b0}}, retire};
         cdb_done <= retire ? 1'b0 : cdb_done | cdb_fire;
         rob_done <= retire ? 1'b0 : rob_done | rob_fire;
      end
   end
endmodule

// File: tb/tb_branch_fu_q.sv
// tb_branch_fu_q: directed table vectors plus multi-cycle sequences for branch_fu_q.
module tb_branch_fu_q;
   logic            clk = 1'b0, rst = 1'b0, input_transmit = 1'b0;
   logic [7:0]      operand = '0, wbs = '0, flags = '0;
   logic [1:0][7:0] depvals = '0;
   logic [7:0]      pc = '0;
   logic [3:0]      robid = '0;
   logic            cdb_transmit = 1'b0, rob_transmit = 1'b0;
   logic            cdb_transmit_out, rob_transmit_out, busy;
   logic [3:0]      cdb_id, robid_out;
   logic [7:0]      cdb_val, flags_out, wbs_out, value_out;
   int              n_cmp = 0, n_bad = 0;

   branch_fu_q dut (
      .clk(clk), .rst(rst), .input_transmit(input_transmit), .operand(operand),
      .depvals(depvals), .pc(pc), .wbs(wbs), .flags(flags), .robid(robid),
      .cdb_transmit(cdb_transmit), .cdb_transmit_out(cdb_transmit_out),
      .cdb_id(cdb_id), .cdb_val(cdb_val), .rob_transmit(rob_transmit),
      .rob_transmit_out(rob_transmit_out), .robid_out(robid_out),
      .flags_out(flags_out), .wbs_out(wbs_out), .value_out(value_out), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] cond;
      logic [7:0] a, b, pc;
      logic       rel;
      logic [7:0] flg, wbs;
      logic [3:0] id;
      logic [7:0] exp_flg, exp_tgt;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [3:0] id, input logic [3:0] cond, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] flg, input logic [7:0] w,
                       input logic rel, input logic [7:0] p);
      robid = id;
      operand = {cond, 3'b000, rel};
      depvals[0] = a;
      depvals[1] = b;
      flags = flg;
      wbs = w;
      pc = p;
      input_transmit = 1'b1;
      @(negedge clk);
      input_transmit = 1'b0;
   endtask

   task automatic step(input logic c, input logic r);
      cdb_transmit = c;
      rob_transmit = r;
      @(negedge clk);
      cdb_transmit = 1'b0;
      rob_transmit = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " req"}, {cdb_transmit_out, rob_transmit_out, busy}, 0);
      chk({tag, " ids"}, {cdb_id, robid_out}, 0);
      chk({tag, " data"}, {cdb_val, value_out, flags_out, wbs_out}, 0);
   endtask

   initial begin
      vecs[0] = '{4'b1010, 8'h00, 8'h3C, 8'h00, 1'b0, 8'hFF, 8'h11, 4'h1, 8'hDF, 8'h3C};
      vecs[1] = '{4'b1010, 8'h05, 8'h3C, 8'h00, 1'b0, 8'h00, 8'h22, 4'h2, 8'h20, 8'h3C};
      vecs[2] = '{4'b1010, 8'h80, 8'h3C, 8'h00, 1'b0, 8'h21, 8'h33, 4'h3, 8'h01, 8'h3C};
      vecs[3] = '{4'b1010, 8'h90, 8'h3C, 8'h00, 1'b0, 8'h00, 8'h44, 4'h4, 8'h20, 8'h3C};
`ifdef BRANCHFU_RELATIVE_EN
      vecs[4] = '{4'b0001, 8'h00, 8'h20, 8'hF0, 1'b1, 8'h00, 8'h55, 4'h5, 8'h20, 8'h10};
`else
      vecs[4] = '{4'b0001, 8'h00, 8'h20, 8'hF0, 1'b1, 8'h00, 8'h55, 4'h5, 8'h20, 8'h20};
`endif
      vecs[5] = '{4'b0000, 8'h00, 8'h20, 8'hF0, 1'b0, 8'h20, 8'h66, 4'h6, 8'h00, 8'h20};

      #1 chk_zero("reset");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) begin
         push(vecs[i].id, vecs[i].cond, vecs[i].a, vecs[i].b, vecs[i].flg, vecs[i].wbs,
              vecs[i].rel, vecs[i].pc);
         chk($sformatf("v%0d req", i), {cdb_transmit_out, rob_transmit_out}, 2'b11);
         chk($sformatf("v%0d flags", i), flags_out, vecs[i].exp_flg);
         chk($sformatf("v%0d cdb_val", i), cdb_val, vecs[i].exp_tgt);
         chk($sformatf("v%0d value", i), value_out, vecs[i].exp_tgt);
         chk($sformatf("v%0d ids", i), {cdb_id, robid_out}, {vecs[i].id, vecs[i].id});
         chk($sformatf("v%0d wbs", i), wbs_out, vecs[i].wbs);
         step(1'b1, 1'b1);
         chk($sformatf("v%0d retired", i), {cdb_transmit_out, rob_transmit_out}, 2'b00);
      end

      // Fill to full, ignore strobes while busy, then drain with dual grants.
      for (int i = 1; i <= 4; i++) begin
         chk($sformatf("fill%0d busy", i), busy, 0);
         push(4'(i), 4'b1111, 8'h01, 8'(i * 16), 8'h00, 8'h00, 1'b0, 8'h00);
      end
      chk("full busy", busy, 1);
      push(4'h8, 4'b1111, 8'h01, 8'h88, 8'h00, 8'h00, 1'b0, 8'h00);
      chk("full ignore head", cdb_id, 4'h1);
      chk("full ignore busy", busy, 1);
      cdb_transmit = 1'b1;
      rob_transmit = 1'b1;
      input_transmit = 1'b1;
      robid = 4'h9;
      @(negedge clk);
      input_transmit = 1'b0;
      chk("drain busy drop", busy, 0);
      for (int i = 2; i <= 4; i++) begin
         chk($sformatf("drain id%0d", i), {cdb_id, robid_out}, {4'(i), 4'(i)});
         chk($sformatf("drain val%0d", i), cdb_val, 8'(i * 16));
         @(negedge clk);
      end
      cdb_transmit = 1'b0;
      rob_transmit = 1'b0;
      chk("drain empty", {cdb_transmit_out, rob_transmit_out, busy}, 0);

      // Grant with no request must not leave a stale done bit.
      step(1'b1, 1'b0);
      push(4'hA, 4'b0000, 8'h00, 8'hAA, 8'h00, 8'h00, 1'b0, 8'h00);
      push(4'hB, 4'b0000, 8'h00, 8'hBB, 8'h00, 8'h00, 1'b0, 8'h00);
      chk("nogrant req", {cdb_transmit_out, rob_transmit_out}, 2'b11);
      step(1'b1, 1'b0);
      chk("split cdb done", {cdb_transmit_out, rob_transmit_out}, 2'b01);
      chk("split hold id", robid_out, 4'hA);
      step(1'b1, 1'b0);
      chk("split wait", {cdb_transmit_out, rob_transmit_out}, 2'b01);
      chk("split wait val", value_out, 8'hAA);
      step(1'b0, 1'b1);
      chk("split next req", {cdb_transmit_out, rob_transmit_out}, 2'b11);
      chk("split next id", {cdb_id, robid_out}, {4'hB, 4'hB});
      step(1'b1, 1'b1);
      chk("split empty", {cdb_transmit_out, rob_transmit_out}, 2'b00);

      // Reset mid-operation with a partially delivered head.
      for (int i = 1; i <= 3; i++)
         push(4'(i + 1), 4'b1111, 8'h01, 8'(8'hC0 + i), 8'hFF, 8'h77, 1'b0, 8'h00);
      step(1'b1, 1'b0);
      chk("pre-rst partial", {cdb_transmit_out, rob_transmit_out}, 2'b01);
      #2 rst = 1'b0;
      #1 chk_zero("mid rst");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_zero("post rst");
      push(4'h7, 4'b0010, 8'h05, 8'h5A, 8'h00, 8'h99, 1'b0, 8'h00);
      chk("post rst req", {cdb_transmit_out, rob_transmit_out}, 2'b11);
      chk("post rst id", {cdb_id, robid_out}, {4'h7, 4'h7});
      chk("post rst data", {cdb_val, flags_out, wbs_out}, {8'h5A, 8'h20, 8'h99});
      step(1'b1, 1'b1);
      chk("post rst empty", {cdb_transmit_out, rob_transmit_out, busy}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/branch_fu_q.md
# branch_fu_q

Parametrised conditional-branch functional unit for the out-of-order core, the successor to the single-slot conditional-jump unit. Accepts one issued branch per cycle, evaluates the condition mask against the sign/zero class of the test operand, computes the target (absolute, or optionally PC-relative), and buffers results in a DEPTH-entry FIFO. Each entry is delivered independently to the CDB and the ROB through per-channel request/grant handshakes. The entry retires only when both channels have taken it.

## Interface
Parameters:
- DATA_W, 8: width of operands, target, CDB value.
- ROBID_W, 4: ROB tag width.
- DEPTH, 4: result FIFO entries; power of two, ≥2.
- TAKEN_BIT, 5: flag bit overwritten with the taken decision.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- input_transmit  in  1  issue strobe; an entry is accepted when high and busy low.
- operand  in  8  [7:4] = cond mask; [0] = relative-target select (used only with the macro).
- depvals  in  2×DATA_W  [0] = test value a; [1] = target/offset b.
- pc  in  DATA_W  branch PC (used only with the macro).
- wbs  in  8  writeback select, passed through.
- flags  in  8  incoming flags.
- robid  in  ROBID_W  ROB tag.
- cdb_transmit  in  1  CDB grant.
- cdb_transmit_out  out  1  CDB request.
- cdb_id  out  ROBID_W  head tag.
- cdb_val  out  DATA_W  head target.
- rob_transmit  in  1  ROB grant.
- rob_transmit_out  out  1  ROB request.
- robid_out  out  ROBID_W  head tag.
- flags_out  out  8  head updated flags.
- wbs_out  out  8  head wbs.
- value_out  out  DATA_W  head target.
- busy  out  1  FIFO full.

## Operation
- Class index: idx = {a[DATA_W-1], |a[DATA_W-2:0]}. 00 = zero, 01 = positive, 10 = most-negative, 11 = other negative.
- taken = cond[idx]. Updated flags = flags with bit TAKEN_BIT replaced by taken.
- Target = b (absolute). With the macro and operand[0]=1, target = pc + b, truncated mod 2^DATA_W.
- Accept (input_transmit & !busy): write {robid, wbs, updated flags, target} at the tail and clear both per-entry done bits. Input_transmit while busy is ignored; no state changes.
- Head outputs are driven from FIFO storage. cdb_transmit_out = head valid & !cdb_done. rob_transmit_out = head valid & !rob_done.
- A grant in a cycle where the matching request is high sets that done bit.
- Head retires (pointer advances, count decrements) in the cycle when both channels are complete: each done bit is already set or is granted this cycle. Simultaneous grants retire the head in one cycle.
- A grant with no request is ignored.
- Data outputs for a channel hold while its request is high. When a request is low, the data outputs are don't-care but must be deterministic (show the head slot).
- busy = (count == DEPTH), combinational from registered count. Enqueue and retire in the same cycle are both applied; count is unchanged.
- Pointers wrap modulo DEPTH.

## Timing
- Reset (asynchronous, rst low): count, pointers, and done bits clear. Every output is 0: requests, ids, values, flags_out, wbs_out, and busy.
- Latency: an entry accepted at edge N, into an empty FIFO, presents requests after edge N (no bypass). With immediate grants, it retires at edge N+1.
- Throughput: one branch per cycle when both grants are held high continuously.
- Reset asserted mid-operation discards all entries, including partially delivered ones. The first cycle after release behaves as empty.

## Configuration
- BRANCHFU_RELATIVE_EN defined: operand[0]=1 selects target = pc + b; operand[0]=0 selects b.
- Not defined: target is always b; pc and operand[0] are ignored; no adder is synthesised.

## Test plan
- Cond 4'b1010: a=0x00 -> flags_out[5]=0; a=0x05 -> flags_out[5]=1; a=0x80 -> 0; a=0x90 -> 1. Target b=0x3C appears on both cdb_val and value_out.
- Four accepts with grants held low -> busy=1 after the 4th. A 5th strobe is ignored. Then grants high -> tags retire in order, one per cycle, busy drops after the first retire.
- CDB granted 2 cycles before ROB -> cdb_transmit_out drops and the ROB request stays. The entry retires only at the ROB grant; the next entry then appears.
- Full FIFO with a simultaneous accept strobe and dual grant -> head retires, the strobe is ignored, and count becomes 3.
- Macro on: pc=0xF0, b=0x20, operand[0]=1 -> target 0x10 (wrap). operand[0]=0 -> target 0x20.
- Assert rst with 3 entries and one CDB done -> all outputs 0 immediately. After release, a new accept is delivered normally.
